// File: rtl/inv_mixcolumns_iter.sv
// Iterative AES InvMixColumns: latches a 128-bit state, transforms one column
// per cycle, then holds the result under a valid/ready handshake.
module inv_mixcolumns_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] outputstate
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] data_q, data_d;
    logic [127:0] result_q, result_d;
    logic [1:0]   col_q, col_d;
    logic [31:0]  col_in, col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k selects which of b, 2b, 4b, 8b are XORed together (e.g. 4'hb = 8b^2b^b)
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gmul = (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] s);
        logic [7:0] b0, b1, b2, b3;
        b0 = s[31:24];
        b1 = s[23:16];
        b2 = s[15:8];
        b3 = s[7:0];
        inv_mix_col[31:24] = gmul(b0, 4'he) ^ gmul(b1, 4'hb) ^ gmul(b2, 4'hd) ^ gmul(b3, 4'h9);
        inv_mix_col[23:16] = gmul(b0, 4'h9) ^ gmul(b1, 4'he) ^ gmul(b2, 4'hb) ^ gmul(b3, 4'hd);
        inv_mix_col[15:8]  = gmul(b0, 4'hd) ^ gmul(b1, 4'h9) ^ gmul(b2, 4'he) ^ gmul(b3, 4'hb);
        inv_mix_col[7:0]   = gmul(b0, 4'hb) ^ gmul(b1, 4'hd) ^ gmul(b2, 4'h9) ^ gmul(b3, 4'he);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            data_q   <= '0;
            result_q <= '0;
            col_q    <= '0;
        end else begin
            fsm_q    <= fsm_d;
            data_q   <= data_d;
            result_q <= result_d;
            col_q    <= col_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid) fsm_d = BUSY;
            BUSY:    if (col_q == 2'd3) fsm_d = DONE;
            DONE:    if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (fsm_q == IDLE);
        out_valid   = (fsm_q == DONE);
        outputstate = result_q;
    end

    always_comb begin
        col_in = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) col_in = data_q[127 - 32*c -: 32];
        end
        col_out = inv_mix_col(col_in);
    end

    // Only the active column is rewritten; the others keep their old contents
    always_comb begin
        data_d   = data_q;
        result_d = result_q;
        col_d    = col_q;
        if (fsm_q == IDLE && in_valid) begin
            data_d = state;
            col_d  = '0;
        end else if (fsm_q == BUSY) begin
            col_d = col_q + 2'd1;
            for (int unsigned c = 0; c < 4; c++) begin
                if (col_q == 2'(c)) result_d[127 - 32*c -: 32] = col_out;
            end
        end
    end

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Scoreboard bench for inv_mixcolumns_iter: directed vectors, backpressure,
// mid-operation reset and a randomised handshake stream.
module tb_inv_mixcolumns_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] outputstate;

    int n_checks = 0;
    int n_pass   = 0;
    int n_recv   = 0;

    logic [127:0] sb_exp[$];
    logic [127:0] sb_in[$];

    inv_mixcolumns_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state      (state),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .outputstate(outputstate)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Generic shift-and-add GF(2^8) multiply, reduction 0x11B
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mat_apply(input logic [127:0] s, input logic [31:0] coefs);
        logic [127:0] r = '0;
        logic [7:0] cf[4];
        cf[0] = coefs[31:24]; cf[1] = coefs[23:16]; cf[2] = coefs[15:8]; cf[3] = coefs[7:0];
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gf_mul(cf[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        return mat_apply(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] ref_fwd(input logic [127:0] s);
        return mat_apply(s, 32'h02030101);
    endfunction

    // Accept/transfer are decided at the next rising edge; inputs are stable here
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sb_exp.push_back(ref_inv(state));
                sb_in.push_back(state);
            end
            if (out_valid && out_ready) begin
                if (sb_exp.size() == 0) begin
                    check("unexpected_output", outputstate, 128'hx);
                end else begin
                    logic [127:0] e, i;
                    e = sb_exp.pop_front();
                    i = sb_in.pop_front();
                    check("sb_result", outputstate, e);
                    check("sb_forward", ref_fwd(outputstate), i);
                    n_recv++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] v);
        int t = 0;
        in_valid = 1'b1;
        state    = v;
        while (!in_ready && t < 50) begin tick(); t++; end
        if (!in_ready) check("send_timeout", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        if (!out_valid) check("valid_timeout", 128'(out_valid), 128'd1);
    endtask

    initial begin
        int lat;
        logic [127:0] snap, cur;
        int sent, cyc;
        bit acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state = '0;
        #12;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_outputstate", outputstate, 128'h0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Basic vector
        out_ready = 1'b1;
        send({4{32'h8e4da1bc}});
        wait_valid(lat);
        check("basic_latency", 128'(lat), 128'd4);
        check("basic_value", outputstate, {4{32'hdb135345}});
        tick();
        check("basic_one_cycle", 128'(out_valid), 128'd0);

        // Mixed columns
        send(128'h9fdc589d_4d7ebdf8_01010101_c6c6c6c6);
        wait_valid(lat);
        check("mixed_value", outputstate, 128'hf20a225c_2d26314c_01010101_c6c6c6c6);
        tick();

        // Backpressure with a second block waiting
        out_ready = 1'b0;
        send(128'h0123456789abcdef_fedcba9876543210);
        in_valid = 1'b1;
        state    = 128'hdeadbeef_cafebabe_00112233_44556677;
        wait_valid(lat);
        check("bp_latency", 128'(lat), 128'd4);
        snap = outputstate;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_stable", outputstate, snap);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_out_valid", 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 128'(out_valid), 128'd0);
        check("bp_release_ready", 128'(in_ready), 128'd1);
        tick();
        check("bp_second_accepted", 128'(in_ready), 128'd0);
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_second_latency", 128'(lat), 128'd4);
        tick();

        // Reset while col=2
        send(128'h11111111_22222222_33333333_44444444);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        check("mid_rst_outputstate", outputstate, 128'h0);
        sb_exp.delete();
        sb_in.delete();
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        state    = {4{32'hd5d5d7d6}};
        tick();
        check("post_rst_accept", 128'(in_ready), 128'd0);
        in_valid = 1'b0;
        wait_valid(lat);
        check("post_rst_latency", 128'(lat), 128'd4);
        check("post_rst_value", outputstate, {4{32'hd4d4d4d5}});
        tick();

        // Randomised stream of 100 blocks
        n_recv = 0;
        sent   = 0;
        cyc    = 0;
        cur    = {$urandom, $urandom, $urandom, $urandom};
        while ((sent < 100 || n_recv < 100) && cyc < 5000) begin
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            state     = cur;
            out_ready = ($urandom_range(0, 2) != 0);
            acc       = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                cur = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        check("rand_received", 128'(n_recv), 128'd100);
        check("rand_drained", 128'(sb_exp.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inv_mixcolumns_iter.md
INV_MIXCOLUMNS_ITER -- requirements
Module: inv_mixcolumns_iter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  input block present.
REQ-004 SHALL have port: in_ready  output  1  block can accept input.
REQ-005 SHALL have port: state  input  128  AES state. Column c = state[127-32c -: 32]; row 0 is in the MSB byte of each column.
REQ-006 SHALL have port: out_valid  output  1  result held on outputstate.
REQ-007 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-008 SHALL have port: outputstate  output  128  InvMixColumns result, packed the same way as state.
REQ-009 SHALL have no parameters; all widths are fixed.

Function
REQ-010 SHALL compute AES InvMixColumns on each column independently, in GF(2^8) with reduction polynomial 0x11B.
REQ-011 SHALL use matrix rows (0e 0b 0d 09), (09 0e 0b 0d), (0d 09 0e 0b), (0b 0d 09 0e).
- Output byte r of a column = XOR over k of M[r][k]·s[k].
REQ-012 SHALL implement the multipliers as xtime chains (x2, x4, x8) combined by XOR; no lookup ROM.
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, and 0 in BUSY and DONE.
REQ-015 SHALL, in IDLE, on an edge where in_valid&in_ready=1: latch state into an internal 128-bit register, clear the 2-bit column counter col to 0, and go to BUSY.
REQ-016 SHALL, in BUSY, transform exactly one column per cycle (column col) and write it into the result register.
- col increments 0→1→2→3.
- When col=3, go to DONE.
REQ-017 SHALL assert out_valid exactly 4 clock edges after the accepting edge, and only in DONE.
REQ-018 SHALL hold outputstate and out_valid stable in DONE until out_ready=1; on out_valid&out_ready, go to IDLE with out_valid=0 on the next cycle.
REQ-019 SHALL ignore in_valid and changes on state while in BUSY/DONE; the latched copy is used.
REQ-020 SHALL NOT accept a new block in the same cycle DONE is released.
- Throughput is one block per 6 cycles minimum with out_ready tied to 1.
REQ-021 SHALL not change outputstate from the moment out_valid rises until the transfer completes.
REQ-022 SHALL keep unprocessed result columns at their previous values during BUSY.
- outputstate is only meaningful while out_valid=1.
REQ-023 SHALL, when out_ready is held 0 indefinitely, remain in DONE with no data loss.

Reset
REQ-024 SHALL, on rst_n=0 (asynchronous, any state including mid-BUSY), immediately force: FSM=IDLE, col=0, out_valid=0, outputstate=128'h0, internal state register=0.
- After rst_n=0, in_ready=1.
REQ-025 SHALL discard any partially processed block on reset; no out_valid may follow for that block.
REQ-026 SHALL, on rst_n release, accept in_valid on the first rising edge where rst_n=1.

Verification
REQ-027 Basic vector
- Stimulus: one block with every column = 8e4da1bc, out_ready=1.
- Response: every output column = db135345; out_valid high 4 edges after acceptance, for 1 cycle.
REQ-028 Mixed columns
- Stimulus: state = 9fdc589d_4d7ebdf8_01010101_c6c6c6c6.
- Response: outputstate = f20a225c_2d26314c_01010101_c6c6c6c6.
REQ-029 Backpressure
- Stimulus: out_ready=0 for 10 cycles after out_valid rises, in_valid held 1 with a different state.
- Response: outputstate stable, in_ready=0 throughout; second block accepted only in the cycle after the handshake.
REQ-030 Reset mid-operation
- Stimulus: assert rst_n=0 when col=2.
- Response: out_valid=0, in_ready=1, outputstate=0 immediately; no result emitted; next block d5d5d7d6 ×4 yields d4d4d4d5 ×4.
REQ-031 Back-to-back
- Stimulus: 100 random blocks, random in_valid/out_ready gaps.
- Response: each output equals the reference-model InvMixColumns result, in order; no drops or duplicates; forward MixColumns of each output returns the input.
